// File: rtl/gate_sweep_pkg.sv
// ---------------------------------------------------------------------------
// gate_sweep_pkg: mode codes, sweep state encoding and the reference gate
// function shared by the sweeper and its reference model.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gate_sweep_pkg;

  localparam int MAX_N = 8;

  localparam logic [2:0] MODE_AND  = 3'b000;
  localparam logic [2:0] MODE_OR   = 3'b001;
  localparam logic [2:0] MODE_NAND = 3'b010;
  localparam logic [2:0] MODE_NOR  = 3'b011;
  localparam logic [2:0] MODE_XOR  = 3'b100;
  localparam logic [2:0] MODE_XNOR = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic mode_is_legal(input logic [2:0] mode);
    return (mode <= MODE_XNOR);
  endfunction

  // Bits of pattern above width are ignored, so one function serves every N.
  function automatic logic expected(input logic [MAX_N-1:0] pattern,
                                    input logic [2:0]       mode,
                                    input int               width);
    logic [MAX_N-1:0] mask;
    logic             all1;
    logic             any1;
    logic             par;
    mask = (width >= MAX_N) ? {MAX_N{1'b1}}
                            : MAX_N'((32'd1 << width) - 32'd1);
    all1 = &(pattern | ~mask);
    any1 = |(pattern & mask);
    par  = ^(pattern & mask);
    case (mode)
      MODE_AND:  return all1;
      MODE_OR:   return any1;
      MODE_NAND: return ~all1;
      MODE_NOR:  return ~any1;
      MODE_XOR:  return par;
      MODE_XNOR: return ~par;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_ref_model.sv
// ---------------------------------------------------------------------------
// gate_ref_model: combinational expected output of the selected N-input gate
// for the current stimulus pattern.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gate_ref_model
  import gate_sweep_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] stim,
  input  logic [2:0]   mode,
  output logic         exp_y
);

  logic [MAX_N-1:0] pattern;

  generate
    if (N < MAX_N) begin : g_pad
      assign pattern = {{(MAX_N-N){1'b0}}, stim};
    end else begin : g_full
      assign pattern = stim[MAX_N-1:0];
    end
  endgenerate

  assign exp_y = expected(pattern, mode, N);

endmodule

`default_nettype wire

// File: rtl/gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// gate_sweep_checker: exhaustive truth-table sweeper that drives every input
// pattern to an N-input gate and counts mismatches.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int N    = 3,
  parameter int HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   mode,
  input  logic         dut_y,
  output logic [N-1:0] stim,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_cnt,
  output logic         fail_valid,
  output logic [N-1:0] first_fail
);

  localparam int            HW        = (HOLD > 2) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  generate
    if ((N < 1) || (N > MAX_N)) begin : g_bad_n
      $error("gate_sweep_checker: N must be in 1..8");
    end
    if (HOLD < 2) begin : g_bad_hold
      $error("gate_sweep_checker: HOLD must be at least 2");
    end
  endgenerate

  state_t         state_q, state_d;
  logic [N-1:0]   stim_q, stim_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [2:0]     mode_q, mode_d;
  logic [N:0]     err_q, err_d;
  logic           fail_valid_q, fail_valid_d;
  logic [N-1:0]   first_fail_q, first_fail_d;
  logic           pass_q, pass_d;

  logic           exp_y;
  logic           sample;
  logic           mismatch;

  gate_ref_model #(.N(N)) u_ref (
    .stim  (stim_q),
    .mode  (mode_q),
    .exp_y (exp_y)
  );

  always_comb begin
    state_d      = state_q;
    stim_d       = stim_q;
    hold_d       = hold_q;
    mode_d       = mode_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;
    sample       = (state_q == ST_RUN) && (hold_q == HOLD_LAST);
    mismatch     = sample && (dut_y != exp_y);

    case (state_q)
      ST_IDLE: begin
        if (start && mode_is_legal(mode)) begin
          mode_d       = mode;
          err_d        = '0;
          fail_valid_d = 1'b0;
          first_fail_d = '0;
          pass_d       = 1'b0;
          stim_d       = '0;
          hold_d       = '0;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mismatch) begin
          err_d = err_q + (N+1)'(1);
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            first_fail_d = stim_q;
          end
        end
        // pass must already reflect a mismatch on the final pattern.
        if (sample) begin
          if (&stim_q) begin
            state_d = ST_DONE;
            pass_d  = (err_d == '0);
          end else begin
            stim_d = stim_q + N'(1);
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        stim_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      stim_q       <= '0;
      hold_q       <= '0;
      mode_q       <= MODE_AND;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stim_q       <= stim_d;
      hold_q       <= hold_d;
      mode_q       <= mode_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fail_valid_q;
  assign first_fail = first_fail_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_sweep_checker: directed and randomized sweeps of two sweeper
// instances (N=3/HOLD=4 and N=1/HOLD=2) against a behavioural gate model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start3 = 1'b0;
  logic       start1 = 1'b0;
  logic [2:0] mode_in = 3'd0;

  logic [2:0] stim3, first_fail3;
  logic [3:0] err3;
  logic       busy3, done3, pass3, fv3, dut_y3;
  logic [0:0] stim1, first_fail1;
  logic [1:0] err1;
  logic       busy1, done1, pass1, fv1, dut_y1;

  // Simulated gate under test: a function code (7 = stuck at 0) plus flips.
  logic [2:0] dut_func = 3'd0;
  logic [7:0] fault_mask = 8'd0;

  int n_tests = 0;
  int n_fail  = 0;

  bit         sel = 1'b0;
  logic       o_busy, o_done, o_pass, o_fv;
  logic [7:0] o_stim, o_ff;
  logic [8:0] o_err;

  logic       last_pass;
  logic [8:0] last_err;
  logic       last_fv;
  logic [7:0] last_ff;

  always #5 clk = ~clk;

  gate_sweep_checker #(.N(3), .HOLD(4)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .mode(mode_in), .dut_y(dut_y3),
    .stim(stim3), .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
    .fail_valid(fv3), .first_fail(first_fail3)
  );

  gate_sweep_checker #(.N(1), .HOLD(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode_in), .dut_y(dut_y1),
    .stim(stim1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_valid(fv1), .first_fail(first_fail1)
  );

  // Gate functions by counting ones: all set, any set, odd count.
  function automatic logic tb_gate(input logic [2:0] f, input logic [7:0] p, input int n);
    int pop;
    pop = $countones(p);
    case (f)
      3'd0:    return (pop == n);
      3'd1:    return (pop != 0);
      3'd2:    return (pop != n);
      3'd3:    return (pop == 0);
      3'd4:    return (pop % 2 == 1);
      3'd5:    return (pop % 2 == 0);
      default: return 1'b0;
    endcase
  endfunction

  always_comb dut_y3 = tb_gate(dut_func, 8'(stim3), 3) ^ fault_mask[stim3];
  always_comb dut_y1 = tb_gate(dut_func, 8'(stim1), 1) ^ fault_mask[stim1];

  always_comb begin
    if (sel) begin
      o_busy = busy1; o_done = done1; o_pass = pass1; o_fv = fv1;
      o_stim = 8'(stim1); o_ff = 8'(first_fail1); o_err = 9'(err1);
    end else begin
      o_busy = busy3; o_done = done3; o_pass = pass3; o_fv = fv3;
      o_stim = 8'(stim3); o_ff = 8'(first_fail3); o_err = 9'(err3);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) start1 = v; else start3 = v;
  endtask

  task automatic run_sweep(input bit s, input logic [2:0] m, input logic [2:0] df,
                           input logic [7:0] fm, input bit repulse, input bit chg_mode);
    int  n, hold, total, errs, first;
    bit  fv;
    sel        = s;
    dut_func   = df;
    fault_mask = fm;
    n     = s ? 1 : 3;
    hold  = s ? 2 : 4;
    total = (1 << n) * hold;
    errs  = 0;
    fv    = 1'b0;
    first = 0;
    for (int p = 0; p < (1 << n); p++) begin
      if (tb_gate(m, 8'(p), n) != (tb_gate(df, 8'(p), n) ^ fm[p])) begin
        errs++;
        if (!fv) begin fv = 1'b1; first = p; end
      end
    end
    @(negedge clk);
    mode_in = m;
    set_start(s, 1'b1);
    @(negedge clk);
    set_start(s, 1'b0);
    if (chg_mode) mode_in = 3'($urandom_range(0, 7));
    for (int c = 1; c <= total; c++) begin
      if (c > 1) @(negedge clk);
      check("run_busy_done_stim", 32'({o_busy, o_done, o_stim}),
            32'({1'b1, 1'b0, 8'((c - 1) / hold)}));
      set_start(s, (repulse && c == 2) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    check("done_busy_done_stim", 32'({o_busy, o_done, o_stim}),
          32'({1'b0, 1'b1, 8'((1 << n) - 1)}));
    check("done_pass", 32'(o_pass), 32'(errs == 0));
    check("done_err_cnt", 32'(o_err), 32'(errs));
    check("done_fail_valid", 32'(o_fv), 32'(fv));
    check("done_first_fail", 32'(o_ff), 32'(first));
    @(negedge clk);
    check("after_busy_done_stim", 32'({o_busy, o_done, o_stim}), 32'd0);
    check("after_pass_held", 32'(o_pass), 32'(errs == 0));
    last_pass = (errs == 0);
    last_err  = 9'(errs);
    last_fv   = fv;
    last_ff   = 8'(first);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit         done_seen;
    bit         rs;
    logic [2:0] rm, rdf;
    logic [7:0] rfm;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_dut3", 32'({busy3, done3, pass3, fv3, err3, first_fail3, stim3}), 32'd0);
    check("reset_dut1", 32'({busy1, done1, pass1, fv1, err1, first_fail1, stim1}), 32'd0);
    rst = 1'b0;

    // Correct AND gate, then stuck-at-0, then XOR reference against an AND.
    run_sweep(1'b0, 3'd0, 3'd0, 8'd0, 1'b0, 1'b0);
    run_sweep(1'b0, 3'd0, 3'd7, 8'd0, 1'b0, 1'b0);
    run_sweep(1'b0, 3'd4, 3'd0, 8'd0, 1'b0, 1'b0);

    // Reserved mode must be ignored with prior results left intact.
    sel = 1'b0;
    @(negedge clk);
    mode_in = 3'b110;
    start3  = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("reserved_busy_done_stim", 32'({o_busy, o_done, o_stim}), 32'd0);
      @(negedge clk);
    end
    check("reserved_results_kept", 32'({o_pass, o_fv, o_err, o_ff}),
          32'({last_pass, last_fv, last_err, last_ff}));

    // Reset in the middle of a sweep, while pattern 5 is driven.
    dut_func   = 3'd0;
    fault_mask = 8'd0;
    mode_in    = 3'd0;
    start3     = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat (21) @(negedge clk);
    check("pre_reset_stim", 32'(stim3), 32'd5);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", 32'({busy3, done3, pass3, fv3, err3, first_fail3, stim3}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done3 || busy3) done_seen = 1'b1;
    end
    check("no_activity_after_reset", 32'(done_seen), 32'd0);
    run_sweep(1'b0, 3'd0, 3'd0, 8'd0, 1'b0, 1'b0);

    // N=1 NOR reference against an inverter, start re-pulsed mid-sweep.
    run_sweep(1'b1, 3'd3, 3'd3, 8'd0, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      rs  = 1'($urandom_range(0, 1));
      rm  = 3'($urandom_range(0, 5));
      rdf = ($urandom_range(0, 1) == 1) ? rm : 3'($urandom_range(0, 7));
      rfm = 8'($urandom) & 8'($urandom);
      run_sweep(rs, rm, rdf, rfm, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Self-checking exhaustive truth-table sweeper for N-input logic gates. On a start request it drives every input pattern from 0 to 2^N−1 onto the device under test, holding each pattern for HOLD cycles, and compares the DUT output against the selected reference function. It counts mismatches and reports pass/fail with a done pulse. It replaces the free-running toggle stimulus used in the gate labs with a single-clock, synthesizable, parametrised sweep usable on the board or in simulation.

## Interface
- N, default 3: number of DUT inputs; legal range 1..8.
- HOLD, default 4: cycles each pattern is held; minimum 2.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  sweep request; sampled only in IDLE.
- mode  in  3  reference function: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR; 110 and 111 are reserved.
- dut_y  in  1  DUT output, synchronous to clk.
- stim  out  N  pattern driven to the DUT inputs.
- busy  out  1  high while a sweep is running.
- done  out  1  one-cycle pulse at the end of a sweep.
- pass  out  1  equals (err_cnt == 0); updated with done and held until the next accepted start.
- err_cnt  out  N+1  number of mismatches in the last or current sweep.
- fail_valid  out  1  at least one mismatch has been recorded.
- first_fail  out  N  pattern of the first mismatch; valid only when fail_valid is high.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - start=1 with a legal mode:
    - latch mode;
    - clear err_cnt, fail_valid, first_fail and pass;
    - stim=0, hold_cnt=0;
    - go to RUN.
  - start=1 with a reserved mode: ignored; stay in IDLE, no outputs change.
- **RUN**
  - stim is held while hold_cnt counts 0..HOLD−1.
  - At hold_cnt==HOLD−1, compare dut_y with expected(stim, latched mode).
  - On a mismatch:
    - increment err_cnt;
    - if fail_valid is 0, load first_fail=stim and set fail_valid.
  - If stim is all ones, go to DONE. Otherwise stim+1 and hold_cnt=0.
- **DONE**
  - Lasts one cycle: done=1, busy=0, pass=(err_cnt==0).
  - Go to IDLE; stim returns to 0.
- start is ignored in RUN and DONE. A mode change mid-sweep has no effect, because the latched copy is used.
- err_cnt cannot overflow: at most 2^N mismatches, which fits in N+1 bits.
- stim does not wrap. The all-ones pattern ends the sweep.

## Timing
- Reset values: stim=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, first_fail=0; state=IDLE.
- Start accepted on edge k:
  - busy=1 and stim=0 from cycle k+1;
  - pattern p is driven in cycles k+1+p·HOLD through k+(p+1)·HOLD;
  - dut_y is sampled on the last of those cycles.
- done is high in cycle k+1+2^N·HOLD. busy is high for exactly 2^N·HOLD cycles.
- err_cnt and first_fail update on the edge following their sample cycle, so they are final when done is seen.
- The DUT may have up to HOLD−1 cycles of combinational or registered delay.
- Reset asserted mid-sweep: all outputs take their reset values asynchronously and no done pulse is produced. A start after reset release begins a fresh sweep.
- Back-to-back sweeps: start is sampled in the IDLE cycle after DONE, so the minimum gap between sweeps is 1 cycle.

## Structure
- Package gate_sweep_pkg holds:
  - mode code localparams (MODE_AND … MODE_XNOR);
  - the state encoding;
  - the function expected(pattern, mode) implementing the reduction &, |, ~&, ~|, ^, ~^ over N bits.
- Sub-module gate_ref_model is combinational: it takes stim and mode and produces exp_y, and is shared with the lab testbenches.
- Parameter checks (N in 1..8, HOLD≥2) are elaboration-time assertions.

## Test plan
- N=3, HOLD=4, mode=AND, DUT is a correct 3-input AND:
  - stim steps 0..7, each held for 4 cycles;
  - busy high for 32 cycles;
  - done pulses once; pass=1, err_cnt=0, fail_valid=0.
- mode=AND, dut_y tied to 0:
  - err_cnt=1, fail_valid=1, first_fail=3'b111, pass=0.
- mode=XOR, DUT is a 3-input AND:
  - mismatches at patterns 1, 2 and 4;
  - err_cnt=3, first_fail=3'b001, pass=0.
- mode=3'b110 with start pulsed:
  - busy stays 0, no done, stim=0, and all outputs keep their prior values.
- Start a correct AND sweep, then assert rst while stim=5:
  - all outputs return to reset values immediately and no done pulse follows;
  - a second start then completes with pass=1.
- N=1, HOLD=2, mode=NOR, DUT is an inverter, start re-pulsed during RUN:
  - re-pulse is ignored;
  - busy high for 4 cycles, done once, pass=1.
